// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues imem reads under a credit limit and
// queues returned instructions for decode; redirects squash queued and in-flight work.
module fetch_sequencer #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = 32'h0100_0000,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AWIDTH-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [AWIDTH-1:0] dec_pc,
    output logic [DWIDTH-1:0] dec_insn,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic [1:0]        inflight_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];
    typedef enum logic {BOOT, RUN} state_t;
    state_t state;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [AWIDTH-1:0] q_pc [DEPTH];
    logic [DWIDTH-1:0] q_insn [DEPTH];
    logic pop;
    logic push;
    logic rsp;
    logic issue;
    logic [CW:0] credit;
    logic [IW-1:0] wr_idx;
    logic [AWIDTH-1:0] target;

    assign target = {redirect_pc[AWIDTH-1:2], 2'b00};
    assign dec_valid = count != '0;
    assign pop = dec_valid && dec_ready;
    // a response with nothing outstanding is left over from before reset
    assign rsp = imem_rsp_valid && inflight != '0;
    assign push = rsp && !redirect_valid && drop == '0;
    assign credit = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign imem_req_valid = state == RUN && !redirect_valid && credit < DEPTH_C;
    assign issue = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc_q;
    assign dec_pc = dec_valid ? q_pc[0] : '0;
    assign dec_insn = dec_valid ? q_insn[0] : '0;
    assign inflight_cnt = 2'(inflight);
    assign wr_idx = IW'(count - CW'(pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc_q <= RESET_PC;
            resp_pc <= RESET_PC;
            inflight <= '0;
            drop <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i] <= '0;
                q_insn[i] <= '0;
            end
        end else begin
            state <= RUN;
            inflight <= inflight + CW'(issue) - CW'(rsp);
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    q_pc[i] <= q_pc[i+1];
                    q_insn[i] <= q_insn[i+1];
                end
            end
            if (push) begin
                q_pc[wr_idx] <= resp_pc;
                q_insn[wr_idx] <= imem_rsp_data;
            end
            // every request still outstanding after a redirect belongs to the old path
            if (redirect_valid) begin
                pc_q <= target;
                resp_pc <= target;
                count <= '0;
                drop <= inflight - CW'(rsp);
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (issue)
                    pc_q <= pc_q + AWIDTH'(4);
                if (push)
                    resp_pc <= resp_pc + AWIDTH'(4);
                if (rsp && drop != '0)
                    drop <= drop - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized traffic against a queue-based model of the fetch
// front end; the bench plays instruction memory with a configurable fixed latency.
module tb_fetch_sequencer;
    localparam logic [31:0] RST_PC = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_insn;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [1:0]  inflight_cnt;

    fetch_sequencer dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_pc(dec_pc),
        .dec_insn(dec_insn),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mem[$];
    logic [31:0] mq[$];
    logic [31:0] popped[$];
    logic [31:0] fpc = RST_PC;
    int cyc = 0;
    int lat = 1;
    int first_valid = -1;
    int vectors = 0;
    int errors = 0;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_insn", dec_insn, 32'd0);
        check("rst_inflight", 32'(inflight_cnt), 32'd0);
    endtask

    task automatic clear_model();
        mem.delete();
        mq.delete();
        popped.delete();
        fpc = RST_PC;
        first_valid = -1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        dec_ready = 1'b0;
        imem_req_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    // One cycle: drive inputs, compare outputs with the model, advance the model past the edge.
    task automatic cycle(input int pd, input int pr, input int px, input logic fr, input logic [31:0] fpc_tgt);
        logic        redir;
        logic        rsp;
        logic        pop;
        logic        exp_req;
        logic        issue;
        logic [31:0] rpc;
        req_t        r;
        redir = cyc >= 1 && (fr || $urandom_range(99) < px);
        rpc = fr ? fpc_tgt : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
        redirect_valid = redir;
        redirect_pc = rpc;
        dec_ready = $urandom_range(99) < pd;
        imem_req_ready = $urandom_range(99) < pr;
        rsp = mem.size() > 0 && mem[0].due <= cyc;
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? insn_of(mem[0].addr) : $urandom;
        #1;
        if (dec_valid && first_valid < 0)
            first_valid = cyc;
        pop = mq.size() > 0 && dec_ready;
        exp_req = cyc >= 1 && !redir && (mem.size() + mq.size() - int'(pop)) < 2;
        check("dec_valid", 32'(dec_valid), 32'(mq.size() > 0));
        check("dec_pc", dec_pc, mq.size() > 0 ? mq[0] : 32'd0);
        check("dec_insn", dec_insn, mq.size() > 0 ? insn_of(mq[0]) : 32'd0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        check("req_addr", imem_req_addr, fpc);
        check("inflight", 32'(inflight_cnt), 32'(mem.size()));
        issue = exp_req && imem_req_ready;
        if (pop)
            popped.push_back(mq.pop_front());
        if (rsp) begin
            r = mem.pop_front();
            if (!redir && !r.stale)
                mq.push_back(r.addr);
        end
        if (redir) begin
            mq.delete();
            foreach (mem[i]) mem[i].stale = 1'b1;
            fpc = {rpc[31:2], 2'b00};
        end else if (issue) begin
            mem.push_back('{addr: fpc, due: cyc + lat, stale: 1'b0});
            fpc = fpc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n, input int pd, input int pr, input int px);
        repeat (n) cycle(pd, pr, px, 1'b0, 32'd0);
    endtask

    initial begin
        // streaming with 1-cycle memory and decode always ready
        lat = 1;
        do_reset();
        run(20, 100, 100, 0);
        check("first_valid_cyc", 32'(first_valid), 32'd3);
        check("stream_count", 32'(popped.size()), 32'd17);
        check("stream_first_pc", popped[0], RST_PC);
        check("stream_last_pc", popped[16], RST_PC + 32'd64);
        // decode stall fills the queue and drains the credits
        run(10, 0, 100, 0);
        check("full_dec_valid", 32'(dec_valid), 32'd1);
        check("full_inflight", 32'(inflight_cnt), 32'd0);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        run(10, 100, 100, 0);
        for (int i = 0; i + 1 < popped.size(); i++)
            check("seq_order", popped[i+1], popped[i] + 32'd4);

        // memory not ready holds the request address
        do_reset();
        run(3, 100, 100, 0);
        check("stall_addr0", imem_req_addr, 32'h0100_0008);
        repeat (3) begin
            cycle(100, 0, 0, 1'b0, 32'd0);
            check("stall_addr", imem_req_addr, 32'h0100_0008);
        end
        cycle(100, 100, 0, 1'b0, 32'd0);
        check("stall_next", imem_req_addr, 32'h0100_000C);

        // redirect with two requests in flight on a 3-cycle memory
        lat = 3;
        do_reset();
        run(3, 100, 100, 0);
        check("pre_redir_inflight", 32'(inflight_cnt), 32'd2);
        cycle(100, 100, 0, 1'b1, 32'h0100_0103);
        check("redir_addr", imem_req_addr, 32'h0100_0100);
        check("redir_inflight", 32'(inflight_cnt), 32'd2);
        check("redir_dec_valid", 32'(dec_valid), 32'd0);
        popped.delete();
        run(14, 100, 100, 0);
        check("redir_first_pc", popped[0], 32'h0100_0100);

        // address wraps at the top of the space
        lat = 1;
        do_reset();
        run(3, 100, 100, 0);
        cycle(100, 100, 0, 1'b1, 32'hFFFF_FFF8);
        popped.delete();
        run(8, 100, 100, 0);
        check("wrap0", popped[0], 32'hFFFF_FFF8);
        check("wrap1", popped[1], 32'hFFFF_FFFC);
        check("wrap2", popped[2], 32'h0000_0000);
        check("wrap3", popped[3], 32'h0000_0004);

        // randomized traffic over several memory latencies with random redirects
        for (int ph = 0; ph < 6; ph++) begin
            lat = 1 + ph % 4;
            do_reset();
            run(400, int'($urandom_range(20, 100)), int'($urandom_range(20, 100)), 6);
        end

        // asynchronous reset mid-operation, then a clean restart
        lat = 2;
        do_reset();
        run(30, 70, 80, 0);
        run(1, 0, 100, 0);
        async_reset_check();
        run(10, 100, 100, 0);
        check("restart_first_pc", popped[0], RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
